idecode: RTL and testbench
==========================

# idecode

Instruction decode stage placed directly downstream of `ifetch`. It accepts fetched RV32I instruction words with their PC, and registers the decoded fields (opcode, register indices, funct fields, sign-extended immediate, format) for the execute stage. A two-entry skid buffer lets the stage drive `ifetch`'s `stall_i` from a register while still absorbing one in-flight word when downstream stalls. A flush input discards buffered work on a branch redirect.

## Interface

- `WORD`, 32: instruction/data width; must be 32.
- `ADDR`, 16: PC width; matches the 64k-word instruction memory.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `v_i`  in  1  `inst_i`/`pc_i` valid from `ifetch` (its `inst_o`/`addr_o`).
- `inst_i`  in  WORD  instruction word.
- `pc_i`  in  ADDR  PC of `inst_i`.
- `stall_o`  out  1  backpressure to `ifetch` `stall_i`; registered.
- `flush_i`  in  1  branch redirect; drop all buffered entries.
- `stall_i`  in  1  backpressure from execute stage.
- `v_o`  out  1  decoded outputs valid.
- `pc_o`  out  ADDR  PC of the output instruction.
- `inst_o`  out  WORD  raw output instruction.
- `opcode_o`  out  7  `inst[6:0]`.
- `rd_o`, `rs1_o`, `rs2_o`  out  5 each  `inst[11:7]`, `[19:15]`, `[24:20]`.
- `funct3_o`  out  3  `inst[14:12]`.
- `funct7_o`  out  7  `inst[31:25]`.
- `imm_o`  out  WORD  sign-extended immediate for `fmt_o`; 0 for R and unknown formats.
- `fmt_o`  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- `illegal_o`  out  1  present only with `IDECODE_ILLEGAL_EN`.

## Operation

- Decode is combinational on the input. Decoded results are stored in the OUT register or the SKID register.
- Format by opcode:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → 7.
- Immediate construction:
  - B: `{inst[31],inst[7],inst[30:25],inst[11:8],0}`, sign-extended.
  - J: `{inst[31],inst[19:12],inst[20],inst[30:21],0}`, sign-extended.
  - U: `{inst[31:12],12'b0}`.
- `accept` = `v_i & ~stall_o & ~flush_i`.
- States:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Transitions, with priority `rst` > `flush_i` > others:
  - `rst` or `flush_i` → EMPTY. The input on that cycle is discarded.
  - EMPTY: on `accept`, load OUT → ONE. Otherwise stay EMPTY.
  - ONE, `~stall_i`: on `accept`, load OUT → ONE. Otherwise → EMPTY.
  - ONE, `stall_i`: on `accept`, load SKID → FULL. Otherwise hold.
  - FULL, `~stall_i`: OUT ← SKID → ONE.
  - FULL, `stall_i`: hold. `v_i` is ignored in FULL.
- `stall_o` = (state == FULL). `v_o` = (state != EMPTY).
- While `v_o & stall_i`, all outputs hold stable.
- Data fields are don't-care when `v_o=0`, but they are reset to 0.

## Timing

- Latency: an accepted word appears on outputs 1 cycle later.
- Throughput: 1 word/cycle with no stalls.
- `stall_o` rises the cycle after the second word is taken under stall. The single word `ifetch` may launch during that lag is absorbed by SKID.
- Release: `stall_i` falls at cycle t → SKID is on outputs at t+1, and `stall_o` falls at t+1.
- Reset: all outputs are 0 the cycle after `rst`, including `v_o`, `stall_o` and `illegal_o`.
- `flush_i` and `stall_i` both high: flush wins, and `v_o=0` next cycle.

## Configuration

- `IDECODE_ILLEGAL_EN` defined:
  - `illegal_o` exists and is registered alongside the other decoded fields.
  - It is 1 when `inst[1:0] != 2'b11` or `fmt == 7`.
  - Illegal words still flow through the pipeline normally.
- Undefined: the `illegal_o` port and its logic are omitted. Unknown opcodes are visible only as `fmt_o=7`.

## Test plan

- Reset, then `0x00500093` (addi x1,x0,5) with pc 0x0010 → next cycle:
  - `v_o=1`, `opcode_o=0x13`, `rd_o=1`, `rs1_o=0`, `imm_o=5`, `fmt_o=1`, `pc_o=0x0010`.
- Format sweep, each → expected fields:
  - `0x0020A423` (sw) → `imm_o=8`, `rs1_o=1`, `rs2_o=2`, `fmt_o=2`.
  - `0xFE000EE3` (beq, -4) → `imm_o=0xFFFFFFFC`, `fmt_o=3`.
  - `0x123452B7` (lui) → `imm_o=0x12345000`, `rd_o=5`, `fmt_o=4`.
  - `0x008000EF` (jal) → `imm_o=8`, `rd_o=1`, `fmt_o=5`.
- Skid: stream A, B, C on consecutive cycles while `stall_i=1` from the cycle A is on the outputs.
  - A is held on the outputs, and B is captured in SKID.
  - `stall_o=1` from the cycle after B is captured.
  - C, presented while `stall_o=1`, is ignored.
  - Drop `stall_i` → B is output next cycle and `stall_o=0`.
- Flush in FULL: assert `flush_i` for 1 cycle → `v_o=0` and `stall_o=0` next cycle. A new word accepted afterwards appears 1 cycle later.
- Reset mid-stream in FULL: `rst` → all outputs 0 next cycle. No stale SKID data appears after reset releases.
- With `IDECODE_ILLEGAL_EN`:
  - `0x0000007F` → `illegal_o=1`, `fmt_o=7`.
  - `0x00000013` → `illegal_o=0`.
  - `0x00000001` → `illegal_o=1`.

Source files
------------

// File: rtl/idecode.sv
// RV32I decode stage with a two-entry (OUT + SKID) buffer and a registered stall to ifetch.
// Optional illegal-instruction flag enabled by defining IDECODE_ILLEGAL_EN.
module idecode #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  output logic            stall_o,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            v_o,
  output logic [ADDR-1:0] pc_o,
  output logic [WORD-1:0] inst_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [WORD-1:0] imm_o,
  output logic [2:0]      fmt_o
`ifdef IDECODE_ILLEGAL_EN
  ,
  output logic            illegal_o
`endif
);

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [WORD-1:0] inst;
    logic [WORD-1:0] imm;
    logic [2:0]      fmt;
`ifdef IDECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_n;
  dec_t   dec_in, out_q, skid_q;
  logic   accept, ld_out, ld_skid, skid2out;

  always_comb begin
    dec_in      = '0;
    dec_in.pc   = pc_i;
    dec_in.inst = inst_i;
    case (inst_i[6:0])
      7'b0110011:                                     dec_in.fmt = F_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_in.fmt = F_I;
      7'b0100011:                                     dec_in.fmt = F_S;
      7'b1100011:                                     dec_in.fmt = F_B;
      7'b0110111, 7'b0010111:                         dec_in.fmt = F_U;
      7'b1101111:                                     dec_in.fmt = F_J;
      default:                                        dec_in.fmt = F_X;
    endcase
    case (dec_in.fmt)
      F_I:     dec_in.imm = {{20{inst_i[31]}}, inst_i[31:20]};
      F_S:     dec_in.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      F_B:     dec_in.imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                             inst_i[11:8], 1'b0};
      F_U:     dec_in.imm = {inst_i[31:12], 12'b0};
      F_J:     dec_in.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                             inst_i[30:21], 1'b0};
      default: dec_in.imm = '0;
    endcase
`ifdef IDECODE_ILLEGAL_EN
    dec_in.illegal = (inst_i[1:0] != 2'b11) || (dec_in.fmt == F_X);
`endif
  end

  assign stall_o = (state == FULL);
  assign v_o     = (state != EMPTY);
  assign accept  = v_i & ~stall_o & ~flush_i;

  always_comb begin
    state_n  = state;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    skid2out = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          ld_out  = 1'b1;
          state_n = ONE;
        end
        ONE: if (!stall_i) begin
          ld_out  = accept;
          state_n = accept ? ONE : EMPTY;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_n = FULL;
        end
        FULL: if (!stall_i) begin
          skid2out = 1'b1;
          state_n  = ONE;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // Data registers are cleared on reset so every output reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out)        out_q <= dec_in;
      else if (skid2out) out_q <= skid_q;
      if (ld_skid)       skid_q <= dec_in;
    end
  end

  assign pc_o     = out_q.pc;
  assign inst_o   = out_q.inst;
  assign opcode_o = out_q.inst[6:0];
  assign rd_o     = out_q.inst[11:7];
  assign rs1_o    = out_q.inst[19:15];
  assign rs2_o    = out_q.inst[24:20];
  assign funct3_o = out_q.inst[14:12];
  assign funct7_o = out_q.inst[31:25];
  assign imm_o    = out_q.imm;
  assign fmt_o    = out_q.fmt;
`ifdef IDECODE_ILLEGAL_EN
  assign illegal_o = out_q.illegal;
`endif

endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: queue-based buffer model checked every cycle plus literal spot checks.
module tb_idecode;
  logic        clk, rst, v_i, flush_i, stall_i;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        stall_o, v_o;
  logic [15:0] pc_o;
  logic [31:0] inst_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o, fmt_o;
`ifdef IDECODE_ILLEGAL_EN
  logic        illegal_o;
`endif

  idecode #(.WORD(32), .ADDR(16)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_o(stall_o), .flush_i(flush_i), .stall_i(stall_i), .v_o(v_o),
    .pc_o(pc_o), .inst_o(inst_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .fmt_o(fmt_o)
`ifdef IDECODE_ILLEGAL_EN
    , .illegal_o(illegal_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the format table, immediates built arithmetically.
  function automatic int m_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h33:                      return 0;
      7'h13, 7'h03, 7'h67, 7'h73: return 1;
      7'h23:                      return 2;
      7'h63:                      return 3;
      7'h37, 7'h17:               return 4;
      7'h6F:                      return 5;
      default:                    return 7;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int v;
    case (m_fmt(i))
      1: v = (i[31] ? -2048 : 0) + int'(i[30:20]);
      2: v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
      3: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      4: v = int'(i & 32'hFFFFF000);
      5: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
             + int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  typedef struct {logic [31:0] inst; logic [15:0] pc;} ent_t;
  ent_t mq[$];
  bit   live = 0;

  // Model: buffer is an ordered list of at most two words; head is what is on the outputs.
  always @(posedge clk) begin
    bit full, pop, acc;
    if (rst) begin
      mq.delete();
      live = 1;
    end else if (live) begin
      if (flush_i) mq.delete();
      else begin
        full = (mq.size() == 2);
        pop  = (mq.size() > 0) && !stall_i;
        acc  = v_i && !full;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back('{inst_i, pc_i});
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("v_o", {31'b0, v_o}, {31'b0, mq.size() > 0});
      chk("stall_o", {31'b0, stall_o}, {31'b0, mq.size() == 2});
      if (mq.size() > 0) begin
        chk("inst_o", inst_o, mq[0].inst);
        chk("pc_o", {16'b0, pc_o}, {16'b0, mq[0].pc});
        chk("opcode_o", {25'b0, opcode_o}, {25'b0, mq[0].inst[6:0]});
        chk("rd_o", {27'b0, rd_o}, {27'b0, mq[0].inst[11:7]});
        chk("rs1_o", {27'b0, rs1_o}, {27'b0, mq[0].inst[19:15]});
        chk("rs2_o", {27'b0, rs2_o}, {27'b0, mq[0].inst[24:20]});
        chk("funct3_o", {29'b0, funct3_o}, {29'b0, mq[0].inst[14:12]});
        chk("funct7_o", {25'b0, funct7_o}, {25'b0, mq[0].inst[31:25]});
        chk("imm_o", imm_o, m_imm(mq[0].inst));
        chk("fmt_o", {29'b0, fmt_o}, m_fmt(mq[0].inst));
`ifdef IDECODE_ILLEGAL_EN
        chk("illegal_o", {31'b0, illegal_o},
            {31'b0, (mq[0].inst[1:0] != 2'b11) || (m_fmt(mq[0].inst) == 7)});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w, input logic [15:0] p);
    v_i = 1'b1; inst_i = w; pc_i = p;
    step();
    v_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v_o"}, {31'b0, v_o}, 32'd0);
    chk({tag, "_stall_o"}, {31'b0, stall_o}, 32'd0);
    chk({tag, "_inst_o"}, inst_o, 32'd0);
    chk({tag, "_pc_o"}, {16'b0, pc_o}, 32'd0);
    chk({tag, "_imm_o"}, imm_o, 32'd0);
    chk({tag, "_fmt_o"}, {29'b0, fmt_o}, 32'd0);
`ifdef IDECODE_ILLEGAL_EN
    chk({tag, "_illegal_o"}, {31'b0, illegal_o}, 32'd0);
`endif
  endtask

  logic [31:0] tbl [8] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7,
                           32'h008000EF, 32'h002081B3, 32'h00000017, 32'hFFF0A103};
  logic [11:0] pat = 12'b0110_1110_0100;

  initial begin
    rst = 1'b1; v_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; inst_i = '0; pc_i = '0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;

    present(32'h00500093, 16'h0010);
    chk("addi_v", {31'b0, v_o}, 32'd1);
    chk("addi_opcode", {25'b0, opcode_o}, 32'h13);
    chk("addi_rd", {27'b0, rd_o}, 32'd1);
    chk("addi_rs1", {27'b0, rs1_o}, 32'd0);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_fmt", {29'b0, fmt_o}, 32'd1);
    chk("addi_pc", {16'b0, pc_o}, 32'h0010);

    present(32'h0020A423, 16'h0014);
    chk("sw_imm", imm_o, 32'd8);
    chk("sw_rs1", {27'b0, rs1_o}, 32'd1);
    chk("sw_rs2", {27'b0, rs2_o}, 32'd2);
    chk("sw_fmt", {29'b0, fmt_o}, 32'd2);
    present(32'hFE000EE3, 16'h0018);
    chk("beq_imm", imm_o, 32'hFFFFFFFC);
    chk("beq_fmt", {29'b0, fmt_o}, 32'd3);
    present(32'h123452B7, 16'h001C);
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_rd", {27'b0, rd_o}, 32'd5);
    chk("lui_fmt", {29'b0, fmt_o}, 32'd4);
    present(32'h008000EF, 16'h0020);
    chk("jal_imm", imm_o, 32'd8);
    chk("jal_rd", {27'b0, rd_o}, 32'd1);
    chk("jal_fmt", {29'b0, fmt_o}, 32'd5);
    step();

    // Skid: A, B, C back to back, downstream stalled from the cycle A is shown.
    present(32'h00100113, 16'h0100);
    stall_i = 1'b1;
    present(32'h00200193, 16'h0104);
    present(32'h00300213, 16'h0108);
    chk("skid_hold_A", inst_o, 32'h00100113);
    chk("skid_stall_o", {31'b0, stall_o}, 32'd1);
    stall_i = 1'b0;
    step();
    chk("skid_out_B", inst_o, 32'h00200193);
    chk("skid_release_stall_o", {31'b0, stall_o}, 32'd0);
    chk("skid_release_v_o", {31'b0, v_o}, 32'd1);
    step();
    chk("skid_C_dropped", {31'b0, v_o}, 32'd0);

    // Flush while FULL and stalled: flush wins.
    present(32'h00400293, 16'h0200);
    stall_i = 1'b1;
    present(32'h00500313, 16'h0204);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_v_o", {31'b0, v_o}, 32'd0);
    chk("flush_stall_o", {31'b0, stall_o}, 32'd0);
    stall_i = 1'b0;
    present(32'h00600393, 16'h0208);
    chk("post_flush_v", {31'b0, v_o}, 32'd1);
    chk("post_flush_inst", inst_o, 32'h00600393);
    step();

    // Reset while FULL: everything clears and SKID never resurfaces.
    present(32'h00700413, 16'h0300);
    stall_i = 1'b1;
    present(32'h00800493, 16'h0304);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0; stall_i = 1'b0;
    step();
    chk("post_rst_v", {31'b0, v_o}, 32'd0);
    step();
    chk("post_rst_v2", {31'b0, v_o}, 32'd0);

    // Continuous stream with a stall pattern; model checks every cycle.
    for (int k = 0; k < 12; k++) begin
      v_i = 1'b1; inst_i = tbl[k % 8]; pc_i = 16'(k * 4); stall_i = pat[k];
      step();
    end
    v_i = 1'b0; stall_i = 1'b0;
    step(); step(); step();

    present(32'h0000007F, 16'h0400);
    chk("unk_fmt", {29'b0, fmt_o}, 32'd7);
    chk("unk_imm", imm_o, 32'd0);
`ifdef IDECODE_ILLEGAL_EN
    chk("unk_illegal", {31'b0, illegal_o}, 32'd1);
    present(32'h00000013, 16'h0404);
    chk("nop_illegal", {31'b0, illegal_o}, 32'd0);
    present(32'h00000001, 16'h0408);
    chk("rvc_illegal", {31'b0, illegal_o}, 32'd1);
`endif
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
